// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, branch-condition codes, flag bit layout, fetch FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package wisc_pkg;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Flag register layout is {Z,V,N}
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_OV = 3'b110,
        CC_UN = 3'b111
    } ccc_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Control-flow opcodes (11xx) never write the flag register.
    function automatic logic is_ctrl_op(input logic [3:0] op);
        return (op == OP_B) || (op == OP_BR) || (op == OP_PCS) || (op == OP_HLT);
    endfunction

    // B offset: 9-bit signed word offset turned into a 16-bit byte offset.
    function automatic logic [15:0] b_offset(input logic [8:0] imm);
        return {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/pc_control_unit_if.sv
// Fetch-side bundle between the PC control unit and imem/decode/RF/ALU.
// Latency: n/a (wiring only).
// Backpressure: imem_ready low stalls the PC stage; nothing else pushes back.
// Ports: imem_ready/instr from imem, rs_data from RF, alu_* and flag_we from ALU/decode;
//        pc/pc_plus2/instr_valid/branch_taken/flags/hlt/retire_cnt from the PC stage.
interface pc_control_unit_if;
    logic        imem_ready;
    logic [15:0] instr;
    logic [15:0] rs_data;
    logic        alu_z;
    logic        alu_n;
    logic        alu_v;
    logic [2:0]  flag_we;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        branch_taken;
    logic [2:0]  flags;
    logic        hlt;
    logic [15:0] retire_cnt;

    // Datapath/memory side
    modport master (
        output imem_ready, instr, rs_data, alu_z, alu_n, alu_v, flag_we,
        input  pc, pc_plus2, instr_valid, branch_taken, flags, hlt, retire_cnt
    );

    // PC control unit side
    modport slave (
        input  imem_ready, instr, rs_data, alu_z, alu_n, alu_v, flag_we,
        output pc, pc_plus2, instr_valid, branch_taken, flags, hlt, retire_cnt
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Evaluates a 3-bit branch condition code against a {Z,V,N} flag vector.
// Latency: combinational.
// Backpressure: none.
// Ports: ccc (condition code), flags ({Z,V,N}) -> cond_true.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond_true
);
    logic z, v, n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        cond_true = 1'b0;
        case (ccc)
            CC_NE:   cond_true = !z;
            CC_EQ:   cond_true = z;
            CC_GT:   cond_true = !z && !n;
            CC_LT:   cond_true = n;
            CC_GE:   cond_true = z || (!z && !n);
            CC_LE:   cond_true = n || z;
            CC_OV:   cond_true = v;
            CC_UN:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_control_unit.sv
// Fetch-side PC stage: PC register, next-PC select (PC+2/B/BR/HLT), {Z,V,N} flags, retire counter.
// Latency: commit and next PC resolve in the same cycle; pc/flags/hlt/retire_cnt update on the next edge.
// Backpressure: imem_ready low stalls (nothing updates); HALT ignores every input until rst.
// Ports: clk, rst (async active-high), bus (pc_control_unit_if.slave).
module pc_control_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_control_unit_if.slave     bus
);
    state_t      state;
    logic [15:0] pc_q;
    logic [2:0]  flags_q;
    logic        hlt_q;
    logic [15:0] retire_q;

    logic [3:0]  opcode;
    logic        is_b, is_br, is_hlt;
    logic        commit;
    logic        cond_true;
    logic        taken;
    logic [15:0] pc_plus2;
    logic [15:0] next_pc;
    logic [2:0]  alu_flags;
    logic [2:0]  flags_next;

    assign opcode   = bus.instr[15:12];
    assign is_b     = (opcode == OP_B);
    assign is_br    = (opcode == OP_BR);
    assign is_hlt   = (opcode == OP_HLT);
    assign commit   = (state == ST_RUN) && bus.imem_ready;
    assign pc_plus2 = pc_q + 16'd2;

    // Condition sees only the registered flags, never this instruction's ALU result.
    branch_cond_eval u_cond (
        .ccc       (bus.instr[11:9]),
        .flags     (flags_q),
        .cond_true (cond_true)
    );

    assign taken = commit && (is_b || is_br) && cond_true;

    always_comb begin
        next_pc = pc_plus2;
        if (is_hlt)
            next_pc = pc_q;
        else if (taken && is_b)
            next_pc = pc_plus2 + b_offset(bus.instr[8:0]);
        else if (taken && is_br)
            next_pc = bus.rs_data;
    end

    assign alu_flags = {bus.alu_z, bus.alu_v, bus.alu_n};

    always_comb begin
        flags_next = flags_q;
        if (!is_ctrl_op(opcode)) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.flag_we[i])
                    flags_next[i] = alu_flags[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            pc_q     <= RESET_PC;
            flags_q  <= 3'b000;
            hlt_q    <= 1'b0;
            retire_q <= 16'h0000;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.imem_ready) begin
                        pc_q     <= next_pc;
                        flags_q  <= flags_next;
                        retire_q <= retire_q + 16'd1;
                        if (is_hlt) begin
                            state <= ST_HALT;
                            hlt_q <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                    hlt_q <= 1'b1;
                end
                default: begin
                    state <= ST_HALT;
                    hlt_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus2     = pc_plus2;
    assign bus.instr_valid  = commit;
    assign bus.branch_taken = taken;
    assign bus.flags        = flags_q;
    assign bus.hlt          = hlt_q;
    assign bus.retire_cnt   = retire_q;
endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit: reset, stall, B/BR, wrap, flag ordering, halt.
// Latency: n/a.
// Backpressure: drives imem_ready directly.
module tb_pc_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    pc_control_unit_if bus ();

    pc_control_unit #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] NOP = 16'h0000;

    task automatic drive(input logic rdy, input logic [15:0] ins, input logic [15:0] rs,
                         input logic z, input logic v, input logic n, input logic [2:0] we);
        bus.imem_ready = rdy;
        bus.instr      = ins;
        bus.rs_data    = rs;
        bus.alu_z      = z;
        bus.alu_v      = v;
        bus.alu_n      = n;
        bus.flag_we    = we;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        drive(1'b1, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        vec_cnt++; if (bus.pc !== 16'h0000) begin err_cnt++; $display("FAIL reset_pc got=%h exp=0000", bus.pc); end
        vec_cnt++; if (bus.flags !== 3'b000) begin err_cnt++; $display("FAIL reset_flags got=%b exp=000", bus.flags); end
        vec_cnt++; if (bus.hlt !== 1'b0) begin err_cnt++; $display("FAIL reset_hlt got=%b exp=0", bus.hlt); end
        vec_cnt++; if (bus.retire_cnt !== 16'h0) begin err_cnt++; $display("FAIL reset_cnt got=%h exp=0000", bus.retire_cnt); end
        vec_cnt++; if (bus.pc_plus2 !== 16'h0002) begin err_cnt++; $display("FAIL reset_pcp2 got=%h exp=0002", bus.pc_plus2); end
        #2;
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vec_cnt++; if (bus.pc !== 16'(2 * i)) begin err_cnt++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.pc, 16'(2 * i)); end
        end
        vec_cnt++; if (bus.retire_cnt !== 16'd3) begin err_cnt++; $display("FAIL seq_cnt got=%0d exp=3", bus.retire_cnt); end
        // Async reset while stalled, with no clock edge in between
        bus.imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        vec_cnt++; if (bus.pc !== 16'h0000) begin err_cnt++; $display("FAIL async_rst_pc got=%h exp=0000", bus.pc); end
        vec_cnt++; if (bus.retire_cnt !== 16'h0) begin err_cnt++; $display("FAIL async_rst_cnt got=%h exp=0000", bus.retire_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_stall;
        do_reset();
        drive(1'b1, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        tick();
        vec_cnt++; if (bus.pc !== 16'd4) begin err_cnt++; $display("FAIL stall_pre_pc got=%h exp=0004", bus.pc); end
        // Flag writes offered while stalled must be dropped
        drive(1'b0, NOP, 16'h0, 1'b1, 1'b1, 1'b1, 3'b111);
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++; if (bus.instr_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_valid%0d got=%b exp=0", i, bus.instr_valid); end
            tick();
            vec_cnt++; if (bus.pc !== 16'd4) begin err_cnt++; $display("FAIL stall_pc%0d got=%h exp=0004", i, bus.pc); end
            vec_cnt++; if (bus.flags !== 3'b000) begin err_cnt++; $display("FAIL stall_flags%0d got=%b exp=000", i, bus.flags); end
            vec_cnt++; if (bus.retire_cnt !== 16'd2) begin err_cnt++; $display("FAIL stall_cnt%0d got=%0d exp=2", i, bus.retire_cnt); end
        end
        drive(1'b1, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        vec_cnt++; if (bus.instr_valid !== 1'b1) begin err_cnt++; $display("FAIL stall_resume_valid got=%b exp=1", bus.instr_valid); end
        tick();
        vec_cnt++; if (bus.pc !== 16'd6) begin err_cnt++; $display("FAIL stall_resume_pc got=%h exp=0006", bus.pc); end
        vec_cnt++; if (bus.retire_cnt !== 16'd3) begin err_cnt++; $display("FAIL stall_resume_cnt got=%0d exp=3", bus.retire_cnt); end
    endtask

    task automatic test_branch_b;
        do_reset();
        drive(1'b1, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        repeat (4) tick();
        // ADD at pc=8 sets Z
        drive(1'b1, NOP, 16'h0, 1'b1, 1'b0, 1'b0, 3'b111);
        tick();
        vec_cnt++; if (bus.flags !== 3'b100) begin err_cnt++; $display("FAIL b_setz_flags got=%b exp=100", bus.flags); end
        // BEQ -2 words at pc=10 -> 8
        drive(1'b1, 16'hC3FE, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        vec_cnt++; if (bus.branch_taken !== 1'b1) begin err_cnt++; $display("FAIL beq_taken got=%b exp=1", bus.branch_taken); end
        tick();
        vec_cnt++; if (bus.pc !== 16'd8) begin err_cnt++; $display("FAIL beq_target got=%h exp=0008", bus.pc); end
        // ADD at pc=8 clears Z
        drive(1'b1, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 3'b111);
        tick();
        drive(1'b1, 16'hC3FE, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        vec_cnt++; if (bus.branch_taken !== 1'b0) begin err_cnt++; $display("FAIL beq_nt got=%b exp=0", bus.branch_taken); end
        tick();
        vec_cnt++; if (bus.pc !== 16'd12) begin err_cnt++; $display("FAIL beq_nt_pc got=%h exp=000c", bus.pc); end
    endtask

    task automatic test_br_wrap;
        do_reset();
        drive(1'b1, 16'hDE00, 16'h0040, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        vec_cnt++; if (bus.branch_taken !== 1'b1) begin err_cnt++; $display("FAIL br_taken got=%b exp=1", bus.branch_taken); end
        tick();
        vec_cnt++; if (bus.pc !== 16'h0040) begin err_cnt++; $display("FAIL br_target got=%h exp=0040", bus.pc); end
        // Odd target: bit0 is not masked
        drive(1'b1, 16'hDE00, 16'h1235, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        vec_cnt++; if (bus.pc !== 16'h1235) begin err_cnt++; $display("FAIL br_odd got=%h exp=1235", bus.pc); end
        drive(1'b1, 16'hDE00, 16'hFFFE, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        vec_cnt++; if (bus.pc_plus2 !== 16'h0000) begin err_cnt++; $display("FAIL wrap_pcp2 got=%h exp=0000", bus.pc_plus2); end
        drive(1'b1, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        vec_cnt++; if (bus.pc !== 16'h0000) begin err_cnt++; $display("FAIL wrap_pc got=%h exp=0000", bus.pc); end
        vec_cnt++; if (bus.retire_cnt !== 16'd4) begin err_cnt++; $display("FAIL wrap_cnt got=%0d exp=4", bus.retire_cnt); end
    endtask

    task automatic test_flag_order;
        do_reset();
        // ADD producing zero at pc=0
        drive(1'b1, NOP, 16'h0, 1'b1, 1'b0, 1'b0, 3'b111);
        tick();
        // BNE +2 words at pc=2, while ALU reports nonzero: registered Z=1 must win
        drive(1'b1, 16'hC002, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        vec_cnt++; if (bus.branch_taken !== 1'b0) begin err_cnt++; $display("FAIL bne_nt got=%b exp=0", bus.branch_taken); end
        tick();
        vec_cnt++; if (bus.pc !== 16'd4) begin err_cnt++; $display("FAIL bne_nt_pc got=%h exp=0004", bus.pc); end
        // B with flag_we set must not touch flags
        drive(1'b1, 16'hC002, 16'h0, 1'b0, 1'b1, 1'b1, 3'b111);
        tick();
        vec_cnt++; if (bus.flags !== 3'b100) begin err_cnt++; $display("FAIL b_no_fwrite got=%b exp=100", bus.flags); end
        vec_cnt++; if (bus.pc !== 16'd6) begin err_cnt++; $display("FAIL b_no_fwrite_pc got=%h exp=0006", bus.pc); end
        // Partial write: only V, Z must hold at 1
        drive(1'b1, NOP, 16'h0, 1'b0, 1'b1, 1'b1, 3'b010);
        tick();
        vec_cnt++; if (bus.flags !== 3'b110) begin err_cnt++; $display("FAIL partial_we got=%b exp=110", bus.flags); end
        // BOV +2 words at pc=8 -> 14
        drive(1'b1, 16'hCC02, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        vec_cnt++; if (bus.branch_taken !== 1'b1) begin err_cnt++; $display("FAIL bov_taken got=%b exp=1", bus.branch_taken); end
        tick();
        vec_cnt++; if (bus.pc !== 16'd14) begin err_cnt++; $display("FAIL bov_pc got=%h exp=000e", bus.pc); end
    endtask

    task automatic test_halt;
        do_reset();
        drive(1'b1, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        repeat (10) tick();
        vec_cnt++; if (bus.pc !== 16'd20) begin err_cnt++; $display("FAIL hlt_pre_pc got=%h exp=0014", bus.pc); end
        drive(1'b1, 16'hF000, 16'h0, 1'b1, 1'b1, 1'b1, 3'b111);
        #1;
        vec_cnt++; if (bus.hlt !== 1'b0) begin err_cnt++; $display("FAIL hlt_early got=%b exp=0", bus.hlt); end
        vec_cnt++; if (bus.instr_valid !== 1'b1) begin err_cnt++; $display("FAIL hlt_commit got=%b exp=1", bus.instr_valid); end
        tick();
        vec_cnt++; if (bus.hlt !== 1'b1) begin err_cnt++; $display("FAIL hlt_rise got=%b exp=1", bus.hlt); end
        vec_cnt++; if (bus.pc !== 16'd20) begin err_cnt++; $display("FAIL hlt_pc got=%h exp=0014", bus.pc); end
        vec_cnt++; if (bus.retire_cnt !== 16'd11) begin err_cnt++; $display("FAIL hlt_cnt got=%0d exp=11", bus.retire_cnt); end
        vec_cnt++; if (bus.flags !== 3'b000) begin err_cnt++; $display("FAIL hlt_flags got=%b exp=000", bus.flags); end
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom_range(1)), 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b1, 3'b111);
            #1;
            vec_cnt++; if (bus.instr_valid !== 1'b0) begin err_cnt++; $display("FAIL halt_valid%0d got=%b exp=0", i, bus.instr_valid); end
            vec_cnt++; if (bus.branch_taken !== 1'b0) begin err_cnt++; $display("FAIL halt_taken%0d got=%b exp=0", i, bus.branch_taken); end
            tick();
            vec_cnt++; if (bus.pc !== 16'd20) begin err_cnt++; $display("FAIL halt_pc%0d got=%h exp=0014", i, bus.pc); end
            vec_cnt++; if (bus.hlt !== 1'b1) begin err_cnt++; $display("FAIL halt_hlt%0d got=%b exp=1", i, bus.hlt); end
            vec_cnt++; if (bus.retire_cnt !== 16'd11) begin err_cnt++; $display("FAIL halt_cnt%0d got=%0d exp=11", i, bus.retire_cnt); end
            vec_cnt++; if (bus.flags !== 3'b000) begin err_cnt++; $display("FAIL halt_flags%0d got=%b exp=000", i, bus.flags); end
        end
        rst = 1'b1;
        #1;
        vec_cnt++; if (bus.pc !== 16'h0000) begin err_cnt++; $display("FAIL halt_rst_pc got=%h exp=0000", bus.pc); end
        vec_cnt++; if (bus.hlt !== 1'b0) begin err_cnt++; $display("FAIL halt_rst_hlt got=%b exp=0", bus.hlt); end
        rst = 1'b0;
        drive(1'b1, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        vec_cnt++; if (bus.pc !== 16'd2) begin err_cnt++; $display("FAIL post_halt_pc got=%h exp=0002", bus.pc); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch_b();
        test_br_wrap();
        test_flag_order();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
